// File: rtl/gtxe2_chnl_rx_pkg.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_pkg
// Shared definitions for the GTXE2 channel receive-side sync monitor:
//   - FSM state encoding (LOS/ACQ/SYNC/CHK), visible on the monitor's
//     'state' output, so the values are part of the external contract.
//   - Per-word classification (bad / good comma) from the decoder flags.
// ---------------------------------------------------------------------------
package gtxe2_chnl_rx_pkg;

  localparam logic [1:0] ST_LOS  = 2'd0;
  localparam logic [1:0] ST_ACQ  = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  // Widest data interface supported by the classifier. Narrower interfaces
  // are zero-extended by the caller and the unused lanes masked by nbytes.
  localparam int RX_MAX_BYTES = 8;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic bad;    // disparity error or code violation in any byte
    logic comma;  // at least one comma byte and no error in the word
  } word_class_t;

  // Anything that is not a clean 1 (0, X or Z) reads as 0.
  function automatic logic [RX_MAX_BYTES-1:0] known_ones(
    input logic [RX_MAX_BYTES-1:0] v,
    input int                      nbytes
  );
    logic [RX_MAX_BYTES-1:0] r;
    for (int i = 0; i < RX_MAX_BYTES; i++) begin
      r[i] = (i < nbytes) && (v[i] === 1'b1);
    end
    return r;
  endfunction

  // A word carrying both a comma and an error counts as bad, not comma.
  function automatic word_class_t classify_word(
    input int                      nbytes,
    input logic [RX_MAX_BYTES-1:0] chariscomma,
    input logic [RX_MAX_BYTES-1:0] disperr,
    input logic [RX_MAX_BYTES-1:0] notintable
  );
    word_class_t wc;
    wc.bad   = |(known_ones(disperr, nbytes) | known_ones(notintable, nbytes));
    wc.comma = (|known_ones(chariscomma, nbytes)) && !wc.bad;
    return wc;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_syncmon_if.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_syncmon_if
// Decoder status bundle from the GTXE2 receiver top (RXUSRCLK2 domain)
// into the sync monitor.
//   rxbyteisaligned       aligner status
//   rxchariscomma[BYTES]  per-byte comma flag
//   rxdisperr[BYTES]      per-byte disparity error
//   rxnotintable[BYTES]   per-byte code violation
// Modports: master = receiver side (drives), slave = monitor side.
// ---------------------------------------------------------------------------
interface gtxe2_chnl_rx_syncmon_if #(
  parameter int BYTES = 4
);
  logic             rxbyteisaligned;
  logic [BYTES-1:0] rxchariscomma;
  logic [BYTES-1:0] rxdisperr;
  logic [BYTES-1:0] rxnotintable;

  modport master (
    output rxbyteisaligned,
    output rxchariscomma,
    output rxdisperr,
    output rxnotintable
  );

  modport slave (
    input rxbyteisaligned,
    input rxchariscomma,
    input rxdisperr,
    input rxnotintable
  );
endinterface

// File: rtl/gtxe2_chnl_rx_satcnt.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_satcnt
// 16-bit saturating event counter with synchronous clear.
//   clk    counting clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous clear, wins over inc
//   inc    count one event (ignored once the counter sits at 16'hFFFF)
//   cnt    current count
// Only compiled when GTXE2_RX_SYNCMON_ERRCNT_EN is defined, since it is the
// only build that instantiates it.
// ---------------------------------------------------------------------------
`ifdef GTXE2_RX_SYNCMON_ERRCNT_EN
module gtxe2_chnl_rx_satcnt
  import gtxe2_chnl_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != ERR_CNT_MAX)) begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign cnt = cnt_reg;

endmodule
`endif

// File: rtl/gtxe2_chnl_rx_syncmon.sv
// ---------------------------------------------------------------------------
// gtxe2_chnl_rx_syncmon
// Word-level receive synchronization monitor (acquire / loss FSM loosely
// after IEEE 802.3 clause 36) for the GTXE2 channel model.
//   clk        RXUSRCLK2
//   rst_n      asynchronous active-low reset
//   rx         decoder status bundle (slave modport)
//   cnt_clr    synchronous clear of err_cnt
//   sync       link synchronized (state SYNC or CHK)
//   state      encoded FSM state (LOS=0, ACQ=1, SYNC=2, CHK=3)
//   los_pulse  one cycle on a SYNC/CHK -> LOS transition
//   err_cnt    saturating bad-word count
// Build option GTXE2_RX_SYNCMON_ERRCNT_EN: when defined, err_cnt counts bad
// words in every state and saturates at 16'hFFFF; when undefined, err_cnt
// is tied to 0 and cnt_clr is ignored. The FSM is the same in both builds.
// ---------------------------------------------------------------------------
module gtxe2_chnl_rx_syncmon
  import gtxe2_chnl_rx_pkg::*;
#(
  parameter int BYTES      = 4,
  parameter int ACQ_COMMAS = 3,
  parameter int LOSS_ERRS  = 4,
  parameter int GOOD_RUN   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  gtxe2_chnl_rx_syncmon_if.slave         rx,
  input  logic                           cnt_clr,
  output logic                           sync,
  output logic [1:0]                     state,
  output logic                           los_pulse,
  output logic [15:0]                    err_cnt
);

  localparam logic [3:0] ACQ_TGT  = 4'(ACQ_COMMAS);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_ERRS);
  localparam logic [3:0] RUN_TGT  = 4'(GOOD_RUN);

  // Lanes widened to the classifier's fixed width; extra lanes read as 0.
  logic [RX_MAX_BYTES-1:0] comma_w;
  logic [RX_MAX_BYTES-1:0] disp_w;
  logic [RX_MAX_BYTES-1:0] nit_w;

  genvar gi;
  generate
    for (gi = 0; gi < RX_MAX_BYTES; gi++) begin : g_lane
      if (gi < BYTES) begin : g_used
        assign comma_w[gi] = rx.rxchariscomma[gi];
        assign disp_w[gi]  = rx.rxdisperr[gi];
        assign nit_w[gi]   = rx.rxnotintable[gi];
      end else begin : g_pad
        assign comma_w[gi] = 1'b0;
        assign disp_w[gi]  = 1'b0;
        assign nit_w[gi]   = 1'b0;
      end
    end
  endgenerate

  word_class_t wc;
  logic        aligned;

  assign wc      = classify_word(BYTES, comma_w, disp_w, nit_w);
  assign aligned = (rx.rxbyteisaligned === 1'b1);

  logic [1:0] state_reg, state_next;
  logic [3:0] acq_cnt_reg, acq_cnt_next;
  logic [3:0] err_credit_reg, err_credit_next;
  logic [3:0] good_run_reg, good_run_next;
  logic       sync_reg;
  logic       los_pulse_reg;

  logic [3:0] acq_inc;
  logic [3:0] credit_inc;
  logic [3:0] run_inc;

  assign acq_inc    = acq_cnt_reg + 4'd1;
  assign credit_inc = err_credit_reg + 4'd1;
  assign run_inc    = good_run_reg + 4'd1;

  always_comb begin
    state_next      = state_reg;
    acq_cnt_next    = acq_cnt_reg;
    err_credit_next = err_credit_reg;
    good_run_next   = good_run_reg;

    if (!aligned) begin
      state_next      = ST_LOS;
      acq_cnt_next    = '0;
      err_credit_next = '0;
      good_run_next   = '0;
    end else begin
      case (state_reg)
        ST_LOS: begin
          if (wc.comma) begin
            acq_cnt_next = 4'd1;
            state_next   = (ACQ_TGT == 4'd1) ? ST_SYNC : ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (wc.bad) begin
            state_next   = ST_LOS;
            acq_cnt_next = '0;
          end else if (wc.comma) begin
            acq_cnt_next = acq_inc;
            if (acq_inc == ACQ_TGT) begin
              state_next = ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          if (wc.bad) begin
            good_run_next = '0;
            // With a loss threshold of one, the first error already
            // exhausts the credit, so there is no CHK phase.
            if (LOSS_TGT == 4'd1) begin
              state_next      = ST_LOS;
              err_credit_next = '0;
            end else begin
              state_next      = ST_CHK;
              err_credit_next = 4'd1;
            end
          end
        end
        default: begin // ST_CHK
          if (wc.bad) begin
            good_run_next = '0;
            if (credit_inc == LOSS_TGT) begin
              state_next      = ST_LOS;
              err_credit_next = '0;
            end else begin
              err_credit_next = credit_inc;
            end
          end else if (run_inc == RUN_TGT) begin
            // A full good run repays one credit; the last one returns to SYNC.
            good_run_next   = '0;
            err_credit_next = err_credit_reg - 4'd1;
            if (err_credit_reg == 4'd1) begin
              state_next = ST_SYNC;
            end
          end else begin
            good_run_next = run_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_LOS;
      acq_cnt_reg    <= '0;
      err_credit_reg <= '0;
      good_run_reg   <= '0;
      sync_reg       <= 1'b0;
      los_pulse_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acq_cnt_reg    <= acq_cnt_next;
      err_credit_reg <= err_credit_next;
      good_run_reg   <= good_run_next;
      // SYNC and CHK are exactly the states with bit 1 set.
      sync_reg       <= state_next[1];
      los_pulse_reg  <= state_reg[1] && (state_next == ST_LOS);
    end
  end

  assign state     = state_reg;
  assign sync      = sync_reg;
  assign los_pulse = los_pulse_reg;

`ifdef GTXE2_RX_SYNCMON_ERRCNT_EN
  gtxe2_chnl_rx_satcnt u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (wc.bad),
    .cnt   (err_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_gtxe2_chnl_rx_syncmon.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gtxe2_chnl_rx_syncmon
// Directed bench for the receive sync monitor. A word-level model derived
// from the acquire/loss rules predicts every output after each clock edge;
// literal expectations along the directed sequence pin the model itself.
// ---------------------------------------------------------------------------
module tb_gtxe2_chnl_rx_syncmon;

  localparam int BYTES      = 4;
  localparam int ACQ_COMMAS = 3;
  localparam int LOSS_ERRS  = 4;
  localparam int GOOD_RUN   = 4;
`ifdef GTXE2_RX_SYNCMON_ERRCNT_EN
  localparam bit ERRCNT_ON  = 1'b1;
`else
  localparam bit ERRCNT_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic        sync;
  logic [1:0]  state;
  logic        los_pulse;
  logic [15:0] err_cnt;

  gtxe2_chnl_rx_syncmon_if #(.BYTES(BYTES)) rx_if ();

  gtxe2_chnl_rx_syncmon #(
    .BYTES      (BYTES),
    .ACQ_COMMAS (ACQ_COMMAS),
    .LOSS_ERRS  (LOSS_ERRS),
    .GOOD_RUN   (GOOD_RUN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx_if),
    .cnt_clr   (cnt_clr),
    .sync      (sync),
    .state     (state),
    .los_pulse (los_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- word-level model ----------------
  int m_state, m_acq, m_credit, m_run, m_err;
  bit m_los, m_sync;

  task automatic model_reset();
    m_state = 0; m_acq = 0; m_credit = 0; m_run = 0; m_err = 0;
    m_los = 0; m_sync = 0;
  endtask

  task automatic model_step(input bit al, input logic [3:0] cm, input logic [3:0] dp,
                            input logic [3:0] ni, input bit clr);
    bit bad, com, was_locked;
    bad = |(dp | ni);
    com = (|cm) && !bad;
    was_locked = (m_state == 2) || (m_state == 3);
    if (!al) begin
      m_state = 0; m_acq = 0; m_credit = 0; m_run = 0;
    end else begin
      case (m_state)
        0: if (com) begin
             m_acq = 1;
             m_state = (ACQ_COMMAS == 1) ? 2 : 1;
           end
        1: if (bad) m_state = 0;
           else if (com) begin
             m_acq++;
             if (m_acq == ACQ_COMMAS) m_state = 2;
           end
        2: if (bad) begin
             m_credit = 1; m_run = 0; m_state = 3;
           end
        default: if (bad) begin
             m_credit++; m_run = 0;
             if (m_credit == LOSS_ERRS) begin m_state = 0; m_credit = 0; end
           end else begin
             m_run++;
             if (m_run == GOOD_RUN) begin
               m_run = 0; m_credit--;
               if (m_credit == 0) m_state = 2;
             end
           end
      endcase
    end
    m_los  = was_locked && (m_state == 0);
    m_sync = (m_state >= 2);
    if (ERRCNT_ON) begin
      if (clr) m_err = 0;
      else if (bad && m_err < 65535) m_err++;
    end else begin
      m_err = 0;
    end
  endtask

  // Compare process: model advances on each edge, DUT checked 1 ns later.
  always @(posedge clk) begin
    if (chk_en && rst_n) begin
      model_step(rx_if.rxbyteisaligned, rx_if.rxchariscomma, rx_if.rxdisperr,
                 rx_if.rxnotintable, cnt_clr);
      #1;
      check("mdl_state", 32'(state), 32'(m_state));
      check("mdl_sync", 32'(sync), 32'(m_sync));
      check("mdl_los_pulse", 32'(los_pulse), 32'(m_los));
      check("mdl_err_cnt", 32'(err_cnt), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input bit al, input logic [3:0] cm, input logic [3:0] dp,
                      input logic [3:0] ni, input bit clr);
    @(negedge clk);
    rx_if.rxbyteisaligned = al;
    rx_if.rxchariscomma   = cm;
    rx_if.rxdisperr       = dp;
    rx_if.rxnotintable    = ni;
    cnt_clr               = clr;
    @(posedge clk);
    #2;
  endtask

  task automatic commas(input int n);
    for (int i = 0; i < n; i++) send(1, 4'b0001, 4'b0000, 4'b0000, 0);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: run did not end, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_if.rxbyteisaligned = 1'b1;
    rx_if.rxchariscomma   = '0;
    rx_if.rxdisperr       = '0;
    rx_if.rxnotintable    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_sync", 32'(sync), 0);
    check("rst_los", 32'(los_pulse), 0);
    check("rst_err", 32'(err_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle good word keeps LOS, then acquire with three commas.
    send(1, 4'b0000, 4'b0000, 4'b0000, 0);
    check("idle_state", 32'(state), 0);
    send(1, 4'b0001, 4'b0000, 4'b0000, 0);
    check("acq1_state", 32'(state), 1);
    check("acq1_sync", 32'(sync), 0);
    send(1, 4'b0001, 4'b0000, 4'b0000, 0);
    check("acq2_state", 32'(state), 1);
    send(1, 4'b0001, 4'b0000, 4'b0000, 0);
    check("acq3_state", 32'(state), 2);
    check("acq3_sync", 32'(sync), 1);
    check("acq3_los", 32'(los_pulse), 0);

    // One disparity error, then a full good run back to SYNC.
    send(1, 4'b0000, 4'b0100, 4'b0000, 0);
    check("chk_state", 32'(state), 3);
    check("chk_sync", 32'(sync), 1);
    check("chk_err", 32'(err_cnt), ERRCNT_ON ? 1 : 0);
    for (int i = 0; i < 4; i++) begin
      send(1, 4'b0000, 4'b0000, 4'b0000, 0);
      check($sformatf("repay%0d_state", i), 32'(state), (i == 3) ? 2 : 3);
    end
    check("repay_err", 32'(err_cnt), ERRCNT_ON ? 1 : 0);

    // Clear, then four code violations drop sync.
    send(1, 4'b0000, 4'b0000, 4'b0000, 1);
    check("clr_err", 32'(err_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      send(1, 4'b0000, 4'b0000, 4'b1000, 0);
      check($sformatf("loss%0d_state", i), 32'(state), (i == 3) ? 0 : 3);
      check($sformatf("loss%0d_los", i), 32'(los_pulse), (i == 3) ? 1 : 0);
    end
    check("loss_sync", 32'(sync), 0);
    check("loss_err", 32'(err_cnt), ERRCNT_ON ? 4 : 0);
    send(1, 4'b0000, 4'b0000, 4'b0000, 0);
    check("loss_pulse_end", 32'(los_pulse), 0);

    // Comma with a disparity error during ACQ aborts without los_pulse.
    commas(2);
    check("acqab_pre", 32'(state), 1);
    send(1, 4'b0001, 4'b0001, 4'b0000, 0);
    check("acqab_state", 32'(state), 0);
    check("acqab_los", 32'(los_pulse), 0);

    // Alignment loss for one cycle while in SYNC.
    commas(3);
    check("realign_pre", 32'(state), 2);
    send(0, 4'b0000, 4'b0000, 4'b0000, 0);
    check("unalign_state", 32'(state), 0);
    check("unalign_los", 32'(los_pulse), 1);
    commas(3);
    check("reacq_state", 32'(state), 2);
    check("reacq_sync", 32'(sync), 1);
    check("reacq_los", 32'(los_pulse), 0);

    // Asynchronous reset mid-operation: immediate drop, no los_pulse.
    @(negedge clk);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("arst_sync", 32'(sync), 0);
    check("arst_state", 32'(state), 0);
    check("arst_los", 32'(los_pulse), 0);
    @(posedge clk);
    #2;
    check("arst_los_edge", 32'(los_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;

    // Error counter saturation and clear-over-increment.
    send(1, 4'b0000, 4'b0000, 4'b0000, 1);
    if (ERRCNT_ON) begin
      for (int i = 0; i < 65534; i++) send(1, 4'b0000, 4'b1111, 4'b0000, 0);
      check("sat_pre", 32'(err_cnt), 32'h0000FFFE);
      send(1, 4'b0000, 4'b1111, 4'b0000, 0);
      check("sat_max", 32'(err_cnt), 32'h0000FFFF);
      send(1, 4'b0000, 4'b1111, 4'b0000, 0);
      check("sat_hold", 32'(err_cnt), 32'h0000FFFF);
    end else begin
      send(1, 4'b0000, 4'b1111, 4'b0000, 0);
      send(1, 4'b0000, 4'b1111, 4'b0000, 0);
      check("off_err", 32'(err_cnt), 0);
    end
    send(1, 4'b0000, 4'b1111, 4'b0000, 1);
    check("clr_wins", 32'(err_cnt), 0);

    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_rx_syncmon.md
# gtxe2_chnl_rx_syncmon

Receive-side synchronization monitor for the GTXE2 channel model. It sits directly downstream of the receiver top and consumes its RXUSRCLK2-domain outputs: data-interface words plus the decoder status flags. It runs a word-level acquire/loss state machine, loosely following IEEE 802.3 clause 36, and reports link sync, loss-of-sync events and a saturating error count to the testbench and PCS-level checkers.

## Interface
Parameters:
- BYTES, 4: bytes per input word; must match the receiver's interface width.
- ACQ_COMMAS, 3: consecutive good comma words needed to declare sync; range 1..15.
- LOSS_ERRS, 4: accumulated bad-word credit that drops sync; range 1..15.
- GOOD_RUN, 4: consecutive good words that repay one error credit; range 1..15.

Ports:
- clk  in  1  RXUSRCLK2.
- rst_n  in  1  reset, asynchronous, active-low.
- rxbyteisaligned  in  1  aligner status.
- rxchariscomma  in  BYTES  per-byte comma flag.
- rxdisperr  in  BYTES  per-byte disparity error.
- rxnotintable  in  BYTES  per-byte code violation.
- cnt_clr  in  1  synchronous clear of err_cnt.
- sync  out  1  link synchronized; true in SYNC or CHK.
- state  out  2  encoded FSM state.
- los_pulse  out  1  one-cycle pulse on a SYNC/CHK -> LOS transition.
- err_cnt  out  16  saturating bad-word count.

X/Z on any status input bit is treated as 0.

## Operation
- Word classification, combinational, per cycle:
  - bad = |(rxdisperr | rxnotintable)
  - comma = |rxchariscomma & !bad
  - good = !bad
  - A word carrying both a comma and an error is bad.
- States: LOS=0, ACQ=1, SYNC=2, CHK=3.
- Overriding transition: rxbyteisaligned=0 sends the FSM from any state to LOS and clears acq_cnt, err_credit and good_run.
- LOS:
  - comma -> ACQ with acq_cnt=1, or straight to SYNC if ACQ_COMMAS=1.
  - Otherwise stay in LOS.
- ACQ:
  - bad -> LOS.
  - comma -> acq_cnt+1; when acq_cnt+1 equals ACQ_COMMAS, go to SYNC.
  - Good non-comma word -> hold.
- SYNC:
  - bad -> CHK with err_credit=1, good_run=0.
  - Good word -> stay.
- CHK:
  - bad: err_credit+1 and good_run=0. When err_credit+1 equals LOSS_ERRS, go to LOS.
  - good: good_run+1. When good_run+1 equals GOOD_RUN, set good_run=0 and err_credit-1; if err_credit-1 equals 0, go to SYNC.
- los_pulse is asserted for exactly one cycle on any transition from SYNC or CHK into LOS, including one forced by rxbyteisaligned. It is never asserted for ACQ -> LOS.
- Internal counters are 4 bits wide and never wrap under legal parameters.

## Timing
- All outputs are registered. A word sampled at edge N is reflected in sync, state, los_pulse and err_cnt after edge N.
- Acquisition latency with ACQ_COMMAS=3: good comma words at edges 0, 1, 2 give sync=1 after edge 2.
- Reset values: state=LOS, sync=0, los_pulse=0, err_cnt=0, all internal counters 0.
- Asserting reset mid-operation drops sync immediately (asynchronously) and does not produce los_pulse.
- cnt_clr wins over a simultaneous bad word: err_cnt=0 after that edge.

## Configuration
- GTXE2_RX_SYNCMON_ERRCNT_EN defined:
  - err_cnt increments on every bad word in any state.
  - err_cnt saturates at 16'hFFFF.
- GTXE2_RX_SYNCMON_ERRCNT_EN undefined:
  - Counter logic is removed.
  - err_cnt is tied to 0 and cnt_clr is ignored.
  - The FSM is unaffected.

## Structure
- Shared package gtxe2_chnl_rx_pkg holds:
  - the state encoding (LOS/ACQ/SYNC/CHK constants);
  - the bad/comma classification function, parameterized by BYTES.
- Sub-module gtxe2_chnl_rx_satcnt: a 16-bit saturating counter with clear and increment inputs. It is instantiated only under GTXE2_RX_SYNCMON_ERRCNT_EN.

## Test plan
- Reset release, aligned, 3 consecutive comma words (rxchariscomma=4'b0001) -> state 0,1,1,2; sync=1 after the third word; los_pulse stays 0.
- In SYNC, one word with rxdisperr=4'b0100, then 4 good words -> state 3, then back to 2 after the 4th good word; err_cnt=1 (macro on) or 0 (macro off).
- In SYNC, 4 consecutive words with rxnotintable=4'b1000 -> state reaches LOS on the 4th; los_pulse high for exactly 1 cycle; err_cnt=4 (macro on).
- In ACQ after 2 commas, a word with comma and disparity error together -> LOS; no los_pulse.
- In SYNC, rxbyteisaligned driven to 0 for one cycle -> LOS next edge, los_pulse=1; then 3 commas -> SYNC again.
- Macro on, err_cnt preloaded to 16'hFFFE by 2 extra bad words -> holds at 16'hFFFF; cnt_clr asserted together with a bad word -> 0.
